// File: rtl/cmp_pkg.sv
// Shared definitions for the comparator BIST: FSM states, LFSR constants
// and the {Less,More,Equal} result encoding.
package cmp_pkg;

   typedef enum logic [2:0] {IDLE, DRIVE, WAIT, CHECK, DONE} state_t;

   typedef enum logic [2:0] {
      RES_EQUAL = 3'b001,
      RES_MORE  = 3'b010,
      RES_LESS  = 3'b100
   } result_t;

   // x^32 + x^22 + x^2 + x + 1 in right-shifting Galois form
   localparam logic [31:0] LFSR_POLY    = 32'h8020_0003;
   localparam logic [31:0] DEFAULT_SEED = 32'hACE1_1234;

   function automatic logic [31:0] lfsr_next(input logic [31:0] s);
      return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
   endfunction

endpackage

// File: rtl/cmp_lfsr32.sv
// 32-bit Galois LFSR with synchronous load and step controls.
module cmp_lfsr32
   import cmp_pkg::*;
#(
   parameter logic [31:0] SEED = DEFAULT_SEED
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic        step,
   output logic [31:0] value
);

   always_ff @(posedge clk) begin
      if (rst || load) begin
         value <= SEED;
      end else if (step) begin
         value <= lfsr_next(value);
      end
   end

endmodule

// File: rtl/cmp_bist_driver.sv
// BIST initiator for an N-bit magnitude comparator: drives X/Y vectors,
// checks Less/More/Equal against an inline golden compare, reports results.
module cmp_bist_driver
   import cmp_pkg::*;
#(
   parameter int unsigned    WIDTH       = 16,
   parameter int unsigned    NUM_VECTORS = 256,
   parameter int unsigned    CMP_LATENCY = 0,
   parameter logic [31:0]    SEED        = DEFAULT_SEED
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic [WIDTH-1:0] X,
   output logic [WIDTH-1:0] Y,
   input  logic             Less,
   input  logic             More,
   input  logic             Equal,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [15:0]      err_count,
   output logic [WIDTH-1:0] fail_x,
   output logic [WIDTH-1:0] fail_y
);

   localparam logic [15:0] LAST_IDX  = 16'(NUM_VECTORS - 1);
   localparam logic [15:0] WAIT_LAST = (CMP_LATENCY > 0) ? 16'(CMP_LATENCY - 1) : '0;

   state_t           state;
   state_t           state_nx;
   logic             launch;
   logic             lfsr_step;
   logic [15:0]      idx;
   logic [15:0]      idx_nx;
   logic [15:0]      wait_cnt;
   logic [31:0]      lfsr_q;
   logic [31:0]      lfsr_nx;
   logic [WIDTH-1:0] vec_x;
   logic [WIDTH-1:0] vec_y;
   result_t          exp_res;
   logic [2:0]       got_res;
   logic             mismatch;

   cmp_lfsr32 #(.SEED(SEED)) u_lfsr (
      .clk   (clk),
      .rst   (rst),
      .load  (launch),
      .step  (lfsr_step),
      .value (lfsr_q)
   );

   always_comb begin
      state_nx = state;
      launch   = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               state_nx = DRIVE;
               launch   = 1'b1;
            end
         end
         DRIVE:   state_nx = (CMP_LATENCY > 0) ? WAIT : CHECK;
         WAIT:    if (wait_cnt == WAIT_LAST) state_nx = CHECK;
         CHECK:   state_nx = (idx < LAST_IDX) ? DRIVE : DONE;
         default: state_nx = IDLE;
      endcase
   end

   // The vector is chosen for the index being entered, so the LFSR is
   // stepped and its new value presented in the same edge.
   always_comb begin
      idx_nx    = launch ? '0 : idx + 16'd1;
      lfsr_nx   = lfsr_next(lfsr_q);
      lfsr_step = (state_nx == DRIVE) && !launch && (idx_nx >= 16'd4);
      vec_x     = '0;
      vec_y     = '0;
      if (idx_nx < 16'd4) begin
         case (idx_nx[1:0])
            2'd1:    vec_x = '1;
            2'd2:    vec_y = '1;
            2'd3:    begin vec_x = '1; vec_y = '1; end
            default: ;
         endcase
      end else begin
         vec_x = lfsr_nx[WIDTH-1:0];
         vec_y = (idx_nx[1:0] == 2'b11) ? lfsr_nx[WIDTH-1:0] : lfsr_nx[16 +: WIDTH];
      end
   end

   // The expected triple is always one-hot, so an exact compare also
   // rejects any non-one-hot response.
   always_comb begin
      if (X < Y)      exp_res = RES_LESS;
      else if (X > Y) exp_res = RES_MORE;
      else            exp_res = RES_EQUAL;
      got_res  = {Less, More, Equal};
      mismatch = (state == CHECK) && (got_res != 3'(exp_res));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         idx       <= '0;
         wait_cnt  <= '0;
         X         <= '0;
         Y         <= '0;
         err_count <= '0;
         fail_x    <= '0;
         fail_y    <= '0;
         pass      <= 1'b0;
      end else begin
         state <= state_nx;
         if (launch) begin
            err_count <= '0;
            fail_x    <= '0;
            fail_y    <= '0;
            pass      <= 1'b0;
         end
         if (state_nx == DRIVE) begin
            idx <= idx_nx;
            X   <= vec_x;
            Y   <= vec_y;
         end
         wait_cnt <= (state == WAIT) ? wait_cnt + 16'd1 : '0;
         if (mismatch) begin
            if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
            if (err_count == 16'h0000) begin
               fail_x <= X;
               fail_y <= Y;
            end
         end
         if (state == CHECK && state_nx == DONE) begin
            pass <= (err_count == 16'h0000) && !mismatch;
         end
      end
   end

   always_comb begin
      busy = (state == DRIVE) || (state == WAIT) || (state == CHECK);
      done = (state == DONE);
   end

endmodule

// File: tb/tb_cmp_bist_driver.sv
// Self-checking bench for cmp_bist_driver against good, faulty and
// pipelined comparator models, with a vector-sequence reference model.
module tb_cmp_bist_driver;

   localparam logic [31:0] SEED_DEF = 32'hACE1_1234;
   localparam logic [31:0] SEED_D   = 32'h0378_002C; // first LFSR step yields X=22, Y=444

   logic clk = 1'b0;
   logic rst;
   int   tests;
   int   fails;

   always #5 clk = ~clk;

   // A: 4 vectors, combinational good comparator
   logic startA, ltA, gtA, eqA, busyA, doneA, passA;
   logic [15:0] xA, yA, errA, fxA, fyA;
   // B: defaults, combinational good comparator
   logic startB, ltB, gtB, eqB, busyB, doneB, passB;
   logic [15:0] xB, yB, errB, fxB, fyB;
   // C: 8 vectors, Equal stuck at 0
   logic startC, ltC, gtC, eqC, busyC, doneC, passC;
   logic [15:0] xC, yC, errC, fxC, fyC;
   // D: 8 vectors, Less and More both high on (22,444)
   logic startD, ltD, gtD, eqD, busyD, doneD, passD;
   logic [15:0] xD, yD, errD, fxD, fyD;
   // E/F: 8-bit, 16 vectors, two-stage registered comparator
   logic startE, ltE, gtE, eqE, busyE, doneE, passE;
   logic [7:0]  xE, yE, fxE, fyE;
   logic [15:0] errE;
   logic startF, ltF, gtF, eqF, busyF, doneF, passF;
   logic [7:0]  xF, yF, fxF, fyF;
   logic [15:0] errF;
   logic [2:0]  pE1, pE2, pF1, pF2;

   assign {ltA, gtA, eqA} = {xA < yA, xA > yA, xA == yA};
   assign {ltB, gtB, eqB} = {xB < yB, xB > yB, xB == yB};
   assign {ltC, gtC, eqC} = {xC < yC, xC > yC, 1'b0};
   assign ltD = xD < yD;
   assign gtD = (xD > yD) || (xD == 16'd22 && yD == 16'd444);
   assign eqD = xD == yD;

   always_ff @(posedge clk) begin
      if (rst) begin
         pE1 <= '0; pE2 <= '0; pF1 <= '0; pF2 <= '0;
      end else begin
         pE1 <= {xE < yE, xE > yE, xE == yE};
         pE2 <= pE1;
         pF1 <= {xF < yF, xF > yF, xF == yF};
         pF2 <= pF1;
      end
   end
   assign {ltE, gtE, eqE} = pE2;
   assign {ltF, gtF, eqF} = pF2;

   cmp_bist_driver #(.WIDTH(16), .NUM_VECTORS(4), .CMP_LATENCY(0)) u_a (
      .clk(clk), .rst(rst), .start(startA), .X(xA), .Y(yA), .Less(ltA), .More(gtA),
      .Equal(eqA), .busy(busyA), .done(doneA), .pass(passA), .err_count(errA),
      .fail_x(fxA), .fail_y(fyA));
   cmp_bist_driver u_b (
      .clk(clk), .rst(rst), .start(startB), .X(xB), .Y(yB), .Less(ltB), .More(gtB),
      .Equal(eqB), .busy(busyB), .done(doneB), .pass(passB), .err_count(errB),
      .fail_x(fxB), .fail_y(fyB));
   cmp_bist_driver #(.NUM_VECTORS(8)) u_c (
      .clk(clk), .rst(rst), .start(startC), .X(xC), .Y(yC), .Less(ltC), .More(gtC),
      .Equal(eqC), .busy(busyC), .done(doneC), .pass(passC), .err_count(errC),
      .fail_x(fxC), .fail_y(fyC));
   cmp_bist_driver #(.NUM_VECTORS(8), .SEED(SEED_D)) u_d (
      .clk(clk), .rst(rst), .start(startD), .X(xD), .Y(yD), .Less(ltD), .More(gtD),
      .Equal(eqD), .busy(busyD), .done(doneD), .pass(passD), .err_count(errD),
      .fail_x(fxD), .fail_y(fyD));
   cmp_bist_driver #(.WIDTH(8), .NUM_VECTORS(16), .CMP_LATENCY(2)) u_e (
      .clk(clk), .rst(rst), .start(startE), .X(xE), .Y(yE), .Less(ltE), .More(gtE),
      .Equal(eqE), .busy(busyE), .done(doneE), .pass(passE), .err_count(errE),
      .fail_x(fxE), .fail_y(fyE));
   cmp_bist_driver #(.WIDTH(8), .NUM_VECTORS(16), .CMP_LATENCY(0)) u_f (
      .clk(clk), .rst(rst), .start(startF), .X(xF), .Y(yF), .Less(ltF), .More(gtF),
      .Equal(eqF), .busy(busyF), .done(doneF), .pass(passF), .err_count(errF),
      .fail_x(fxF), .fail_y(fyF));

   // Reference vector for a given index: corners first, then successive LFSR
   // states (one step per vector from index 4), with Y forced to X on index%4==3.
   function automatic logic [31:0] model_vec(input logic [31:0] seed,
                                             input int unsigned idx,
                                             input int unsigned w);
      logic [31:0] s;
      logic [15:0] m, x, y;
      m = 16'((32'h1 << w) - 32'h1);
      if (idx < 4) begin
         x = (idx == 1 || idx == 3) ? m : 16'h0;
         y = (idx == 2 || idx == 3) ? m : 16'h0;
      end else begin
         s = seed;
         for (int unsigned k = 4; k <= idx; k++)
            s = s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
         x = s[15:0] & m;
         y = (idx % 4 == 3) ? x : (s[31:16] & m);
      end
      return {y, x};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(); tick();
      tests++; if ({xA, yA, busyA, doneA, passA, errA, fxA, fyA} !== '0) begin
         fails++; $display("FAIL reset_a got=%h", {xA, yA, busyA, doneA, passA, errA, fxA, fyA}); end
      tests++; if ({xB, yB, busyB, doneB, passB, errB, fxB, fyB} !== '0) begin
         fails++; $display("FAIL reset_b got=%h", {xB, yB, busyB, doneB, passB, errB, fxB, fyB}); end
      tests++; if ({xC, yC, busyC, doneC, passC, errC, fxC, fyC} !== '0) begin
         fails++; $display("FAIL reset_c got=%h", {xC, yC, busyC, doneC, passC, errC, fxC, fyC}); end
      tests++; if ({xD, yD, busyD, doneD, passD, errD, fxD, fyD} !== '0) begin
         fails++; $display("FAIL reset_d got=%h", {xD, yD, busyD, doneD, passD, errD, fxD, fyD}); end
      tests++; if ({xE, yE, busyE, doneE, passE, errE, fxE, fyE} !== '0) begin
         fails++; $display("FAIL reset_e got=%h", {xE, yE, busyE, doneE, passE, errE, fxE, fyE}); end
      tests++; if ({xF, yF, busyF, doneF, passF, errF, fxF, fyF} !== '0) begin
         fails++; $display("FAIL reset_f got=%h", {xF, yF, busyF, doneF, passF, errF, fxF, fyF}); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_corners();
      logic [31:0] e;
      repeat ($urandom_range(1, 5)) tick();
      startA = 1'b1;
      tick();
      startA = 1'b0;
      for (int k = 0; k < 8; k++) begin
         e = model_vec(SEED_DEF, k / 2, 16);
         tests++; if ({yA, xA} !== e) begin
            fails++; $display("FAIL corner_xy k=%0d got x=%h y=%h exp x=%h y=%h", k, xA, yA, e[15:0], e[31:16]); end
         tests++; if ({busyA, doneA} !== 2'b10) begin
            fails++; $display("FAIL corner_busy k=%0d got busy=%b done=%b exp 1 0", k, busyA, doneA); end
         tick();
      end
      tests++; if ({busyA, doneA, passA, errA} !== {3'b011, 16'h0}) begin
         fails++; $display("FAIL corner_done got busy=%b done=%b pass=%b err=%0d exp 0 1 1 0",
                           busyA, doneA, passA, errA); end
   endtask

   task automatic test_default_run();
      logic [31:0] e;
      int k, eq_seen, eq_exp;
      eq_seen = 0; eq_exp = 0; k = 0;
      for (int unsigned i = 0; i < 256; i++) begin
         e = model_vec(SEED_DEF, i, 16);
         if (e[15:0] == e[31:16]) eq_exp++;
      end
      startB = 1'b1;
      tick();
      startB = 1'b0;
      while (busyB && k < 2000) begin
         if (k % 2 == 0) begin
            e = model_vec(SEED_DEF, k / 2, 16);
            tests++; if ({yB, xB} !== e) begin
               fails++; $display("FAIL run_xy idx=%0d got x=%h y=%h exp x=%h y=%h", k / 2, xB, yB, e[15:0], e[31:16]); end
            if (eqB) eq_seen++;
         end
         startB = ($urandom_range(0, 15) == 0);  // must be ignored while busy
         tick();
         k++;
      end
      startB = 1'b0;
      tests++; if (k !== 512) begin
         fails++; $display("FAIL run_busy_cycles got=%0d exp=512", k); end
      tests++; if ({doneB, passB, errB, fxB, fyB} !== {2'b11, 48'h0}) begin
         fails++; $display("FAIL run_result got done=%b pass=%b err=%0d fx=%h fy=%h exp 1 1 0 0 0",
                           doneB, passB, errB, fxB, fyB); end
      tests++; if (eq_seen !== eq_exp || eq_seen < 63) begin
         fails++; $display("FAIL run_equal_count got=%0d exp=%0d (>=63)", eq_seen, eq_exp); end
   endtask

   task automatic test_reset_midrun();
      startB = 1'b1;
      tick();
      startB = 1'b0;
      repeat ($urandom_range(45, 55)) tick();
      tests++; if (busyB !== 1'b1) begin
         fails++; $display("FAIL midrun_busy got=%b exp=1", busyB); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tests++; if ({xB, yB, busyB, doneB, passB, errB, fxB, fyB} !== '0) begin
         fails++; $display("FAIL midrun_reset got=%h exp=0", {xB, yB, busyB, doneB, passB, errB, fxB, fyB}); end
      tick();
      test_default_run();
   endtask

   task automatic test_stuck_equal();
      logic [31:0] e;
      int unsigned mask, exp_mask;
      int k;
      logic [15:0] prev;
      exp_mask = 0;
      for (int unsigned i = 0; i < 8; i++) begin
         e = model_vec(SEED_DEF, i, 16);
         if (e[15:0] == e[31:16]) exp_mask |= (32'h1 << i);
      end
      mask = 0; k = 0;
      startC = 1'b1;
      tick();
      startC = 1'b0;
      prev = errC;
      while (!doneC && k < 200) begin
         tick();
         k++;
         if (errC != prev) begin
            mask |= (32'h1 << (k / 2 - 1));
            prev = errC;
         end
      end
      tests++; if (k >= 200) begin
         fails++; $display("FAIL stuck_timeout got=%0d cycles exp<200", k); end
      tests++; if (mask !== exp_mask) begin
         fails++; $display("FAIL stuck_fail_idx got=%b exp=%b", mask, exp_mask); end
      tests++; if ({errC, fxC, fyC, passC} !== {16'd3, 32'h0, 1'b0}) begin
         fails++; $display("FAIL stuck_result got err=%0d fx=%h fy=%h pass=%b exp 3 0 0 0", errC, fxC, fyC, passC); end
   endtask

   task automatic test_restart();
      int k;
      startC = 1'b1;
      tick();
      startC = 1'b0;
      tests++; if ({busyC, doneC, passC, errC, fxC, fyC, xC, yC} !== {1'b1, 82'h0}) begin
         fails++; $display("FAIL restart_clear got busy=%b done=%b pass=%b err=%0d x=%h y=%h exp 1 0 0 0 0 0",
                           busyC, doneC, passC, errC, xC, yC); end
      k = 0;
      while (!doneC && k < 200) begin tick(); k++; end
      tests++; if (errC !== 16'd3 || k !== 16) begin
         fails++; $display("FAIL restart_rerun got err=%0d cycles=%0d exp 3 16", errC, k); end
   endtask

   task automatic test_onehot();
      int k;
      k = 0;
      startD = 1'b1;
      tick();
      startD = 1'b0;
      while (!doneD && k < 200) begin tick(); k++; end
      tests++; if ({errD, fxD, fyD, passD} !== {16'd1, 16'd22, 16'd444, 1'b0}) begin
         fails++; $display("FAIL onehot got err=%0d fx=%0d fy=%0d pass=%b exp 1 22 444 0", errD, fxD, fyD, passD); end
   endtask

   task automatic test_latency();
      logic [31:0] e;
      int k;
      k = 0;
      startE = 1'b1;
      startF = 1'b1;
      tick();
      startE = 1'b0;
      startF = 1'b0;
      while (busyE && k < 500) begin
         if (k % 4 == 0) begin
            e = model_vec(SEED_DEF, k / 4, 8);
            tests++; if ({yE, xE} !== {e[23:16], e[7:0]}) begin
               fails++; $display("FAIL lat2_xy idx=%0d got x=%h y=%h exp x=%h y=%h", k / 4, xE, yE, e[7:0], e[23:16]); end
         end
         tick();
         k++;
      end
      tests++; if (k !== 64) begin
         fails++; $display("FAIL lat2_busy_cycles got=%0d exp=64", k); end
      tests++; if ({doneE, passE, errE} !== {2'b11, 16'h0}) begin
         fails++; $display("FAIL lat2_result got done=%b pass=%b err=%0d exp 1 1 0", doneE, passE, errE); end
      tests++; if (!(doneF && !passF && errF > 16'd0)) begin
         fails++; $display("FAIL lat0_regdut got done=%b pass=%b err=%0d exp 1 0 >0", doneF, passF, errF); end
   endtask

   initial begin
      tests = 0; fails = 0;
      rst = 1'b1;
      {startA, startB, startC, startD, startE, startF} = '0;
      test_reset();
      test_corners();
      test_default_run();
      test_reset_midrun();
      test_stuck_equal();
      test_restart();
      test_onehot();
      test_latency();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/cmp_bist_driver.md
Name: cmp_bist_driver

Overview:
- Self-test initiator for the N-bit magnitude comparator: generates operand pairs, drives X/Y into a comparator instance, samples its Less/More/Equal outputs, checks them against an internal golden compare, and reports pass/fail plus error count.
- Sits beside the comparator in the design top, or in a BIST wrapper, as the requesting end of its X/Y -> Less/More/Equal interface.

Parameters:
- WIDTH, 16, operand width; legal range 4..16.
- NUM_VECTORS, 256, total vectors per run including the 4 corner vectors; legal range 4..65535.
- CMP_LATENCY, 0, DUT pipeline depth in clocks; 0 means a combinational comparator.
- SEED, 32'hACE1_1234, LFSR load value; must be nonzero.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse that begins a run; honoured only in IDLE or DONE.
- X  out  WIDTH  operand A to the comparator.
- Y  out  WIDTH  operand B to the comparator.
- Less  in  1  comparator result, X<Y.
- More  in  1  comparator result, X>Y.
- Equal  in  1  comparator result, X==Y.
- busy  out  1  high while a run is in progress.
- done  out  1  high from run completion until the next start or rst.
- pass  out  1  valid when done=1; high only if err_count==0.
- err_count  out  16  mismatching vectors, saturates at 16'hFFFF.
- fail_x  out  WIDTH  X of the first failing vector.
- fail_y  out  WIDTH  Y of the first failing vector.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; LFSR loaded with SEED; vector index 0. Reset mid-run aborts at once and no partial result is retained.
- FSM states: IDLE -> DRIVE on start. DRIVE -> WAIT if CMP_LATENCY>0, otherwise -> CHECK. WAIT holds for CMP_LATENCY cycles, then -> CHECK. CHECK -> DRIVE if index<NUM_VECTORS-1, otherwise -> DONE. DONE -> DRIVE on start.
- start in DRIVE, WAIT or CHECK is ignored. start in DONE clears err_count, fail_x, fail_y, done and pass; reloads the LFSR with SEED; resets the index to 0.
- Each vector takes CMP_LATENCY+2 clocks. X/Y are registered outputs that change only on entry to DRIVE and hold until the next DRIVE.
- CHECK samples Less/More/Equal on its clock edge. The expected result is an unsigned compare of the held X/Y.
- A vector fails if the DUT triple is not exactly one-hot, or if it differs from the expected result.
- On a failure, err_count increments (saturating). fail_x/fail_y capture the vector only when err_count was 0 before the increment.
- Vector order:
  - index 0: (0,0)
  - index 1: (all-ones,0)
  - index 2: (0,all-ones)
  - index 3: (all-ones,all-ones)
  - index>=4: 32-bit Galois LFSR, polynomial x^32+x^22+x^2+x+1, advanced once per vector on entry to DRIVE. X=lfsr[WIDTH-1:0], Y=lfsr[16+WIDTH-1:16].
  - Every index with index[1:0]==2'b11 (index>=4) forces Y=X so Equal is exercised.
- busy=1 in DRIVE, WAIT and CHECK.
- done and pass assert in the cycle the FSM enters DONE; pass=(err_count==0) at that point.
- A run with all NUM_VECTORS vectors passing leaves err_count=0, pass=1, fail_x=fail_y=0.

Decomposition:
- Shared package cmp_pkg: FSM state encoding (IDLE, DRIVE, WAIT, CHECK, DONE), the LFSR polynomial constant, the default SEED, and the 3-bit result encoding {Less,More,Equal}.
- One sub-module, cmp_lfsr32: 32-bit Galois LFSR with load and step inputs, reused by later BIST blocks.
- The golden compare stays inline.

Test Plan:
- Good DUT, NUM_VECTORS=4, CMP_LATENCY=0, start at cycle 5 -> X/Y sequence (0,0), (FFFF,0), (0,FFFF), (FFFF,FFFF) at 2-clock spacing; done=1 and pass=1 at cycle 14; err_count=0.
- Good DUT, defaults -> busy high for exactly 512 clocks; pass=1; at least 63 vectors with Equal=1 observed.
- DUT with Equal stuck at 0, NUM_VECTORS=8 -> index 0, index 3 and index 7 fail; err_count=3; fail_x=0, fail_y=0; pass=0.
- DUT asserting Less and More together on X=22,Y=444 (forced at index 4 by the bench) -> counted as an error even though Less is correct; fail_x=22, fail_y=444.
- CMP_LATENCY=2 with a registered DUT -> 4 clocks per vector and pass=1. The same DUT with CMP_LATENCY=0 -> err_count>0.
- rst at cycle 50 of a run, then start -> the second run's X/Y sequence is identical to a fresh run; start pulses while busy=1 have no effect.
